bpc_scheduler: RTL
==================

BPC_SCHEDULER -- requirements
Module: bpc_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, default 24, bits per request word.
REQ-002 SHALL have parameter N_REQ, default 4, number of requesters (>=2).
REQ-003 SHALL have parameter MAX_OUTST, default 2, per-requester in-flight limit (>=1).
REQ-004 SHALL have port clk_i  in  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port arst_ni  in  1  asynchronous active-low reset.
REQ-006 SHALL have port req_data_i  in  N_REQ x WIDTH  per-requester word to count.
REQ-007 SHALL have port req_valid_i  in  N_REQ  per-requester request valid.
REQ-008 SHALL have port req_ready_o  out  N_REQ  per-requester accept; one-hot or zero.
REQ-009 SHALL have port req_en_i  in  N_REQ  per-requester enable mask.
REQ-010 SHALL have port rsp_valid_o  out  N_REQ  one-hot or zero; result belongs to the flagged requester.
REQ-011 SHALL have port rsp_cnt_o  out  CNT_W  shared result bus, CNT_W = $clog2(WIDTH+1).
REQ-012 SHALL have port busy_o  out  1  high while any request is in flight.

Function
REQ-013 SHALL treat a requester as eligible when req_valid_i & req_en_i & (outstanding < MAX_OUTST, or a response for that requester completes this cycle).
REQ-014 SHALL grant at most one eligible requester per cycle, round-robin, highest priority at (last granted + 1) mod N_REQ.
REQ-015 SHALL drive req_ready_o combinationally from the grant; req_ready_o may depend on req_valid_i.
REQ-016 SHALL accept a request when req_valid_i & req_ready_o are both high, and update the RR pointer only on acceptance.
REQ-017 SHALL leave the RR pointer unchanged in idle cycles.
REQ-018 SHALL issue the accepted word and a requester tag into the counting pipeline in the acceptance cycle.
REQ-019 SHALL assert rsp_valid_o[tag] with the popcount of the accepted word exactly LAT cycles after acceptance, for one cycle.
REQ-020 SHALL define LAT = $clog2(2**$clog2(WIDTH)/4) + 1; LAT is 4 for WIDTH = 24.
REQ-021 SHALL sustain one issue and one response per cycle, back-to-back, with no bubbles.
REQ-022 SHALL give rsp_cnt_o the range 0..WIDTH with no overflow; an all-ones word yields WIDTH.
REQ-023 SHALL drive rsp_cnt_o to 0 when no rsp_valid_o bit is set.
REQ-024 SHALL keep a per-requester outstanding counter of width $clog2(MAX_OUTST+1): +1 on accept, -1 on response, unchanged when both occur in the same cycle.
REQ-025 SHALL let a request already in flight complete normally when req_en_i deasserts; only new grants are blocked.
REQ-026 SHALL have no response back-pressure; a response not consumed is lost by design.
REQ-027 SHALL drive busy_o = OR of all outstanding counters being non-zero.

Reset
REQ-028 SHALL, on arst_ni low, immediately clear req_ready_o, rsp_valid_o, rsp_cnt_o, busy_o, all outstanding counters and all pipeline valid/tag flags.
REQ-029 SHALL reset the RR pointer to N_REQ-1, so that requester 0 has first priority.
REQ-030 SHALL discard requests in flight at reset; no response for them appears after arst_ni rises.
REQ-031 SHALL not reset the pipeline data registers.

Structure
REQ-032 SHALL place the CNT_W and LAT functions and the tag width function ($clog2(N_REQ)) in the shared package bpc_pkg.
REQ-033 SHALL instantiate one sub-module, popcount_pipe (input register + 4-bit window adder tree), clocked by clk_i and reset by arst_ni.
REQ-034 SHALL have popcount_pipe carry the valid flag and tag alongside the data with LAT latency.
REQ-035 SHALL keep the arbiter and outstanding counters in bpc_scheduler.

Verification
REQ-036 SHALL cover: requester 1 sends 24'hFFFFFF at cycle T -> rsp_valid_o=4'b0010, rsp_cnt_o=24 at T+4; then 24'h000000 -> rsp_cnt_o=0.
REQ-037 SHALL cover: all four requesters hold valid continuously -> grants in order 0,1,2,3,0,...; each response tagged with its requester.
REQ-038 SHALL cover: requester 2 alone with continuous valid, MAX_OUTST=2 -> accepts at T, T+1, T+4, T+5, ...; ready low at T+2 and T+3.
REQ-039 SHALL cover: req_en_i[0] cleared with one request in flight -> that response still arrives at LAT; no further grants to 0; requester 3 is granted.
REQ-040 SHALL cover: arst_ni low for 1 cycle with 3 requests in flight -> rsp_valid_o=0 at once, no responses after release, busy_o=0, next grant goes to requester 0.
REQ-041 SHALL cover: random words from all requesters for 10k cycles -> every response equals the reference popcount and matches acceptance order per requester.

Source files
------------

// File: rtl/bpc_pkg.sv
// Shared sizing helpers for the popcount scheduler: result width, pipeline latency,
// requester tag width and the number of 4-bit windows in the adder tree.
package bpc_pkg;

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic int lat(input int width);
    return $clog2((2 ** $clog2(width)) / 4) + 1;
  endfunction

  function automatic int tag_w(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

  // Word is zero-padded to a power of two and split into 4-bit windows.
  function automatic int n_win(input int width);
    int p;
    p = 2 ** $clog2(width);
    return (p >= 4) ? p / 4 : 1;
  endfunction

endpackage

// File: rtl/bpc_scheduler_popcount_pipe.sv
// Popcount pipeline: input register, 4-bit window counts, then a registered binary
// adder tree; valid and tag ride alongside so results emerge lat(WIDTH) cycles later.
module popcount_pipe
  import bpc_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int TAG_W = 2
) (
  input  logic                    clk_i,
  input  logic                    arst_ni,
  input  logic                    issue_valid,
  input  logic [TAG_W-1:0]        issue_tag,
  input  logic [WIDTH-1:0]        issue_data,
  output logic                    done_valid,
  output logic [TAG_W-1:0]        done_tag,
  output logic [cnt_w(WIDTH)-1:0] done_cnt
);

  localparam int CW  = cnt_w(WIDTH);
  localparam int LAT = lat(WIDTH);
  localparam int NW  = n_win(WIDTH);
  localparam int PW  = 4 * NW;

  logic [PW-1:0]    data_q;
  logic [CW-1:0]    leaf [NW];
  logic [LAT-1:0]   vld_q;
  logic [TAG_W-1:0] tag_q [LAT];

  // Data path is deliberately left without reset; only valid/tag are cleared.
  always_ff @(posedge clk_i) begin
    data_q <= PW'(issue_data);
  end

  always_comb begin
    for (int w = 0; w < NW; w++) begin
      leaf[w] = '0;
      for (int b = 0; b < 4; b++) begin
        leaf[w] = leaf[w] + CW'(data_q[4*w+b]);
      end
    end
  end

  if (NW == 1) begin : g_flat
    assign done_cnt = leaf[0];
  end else begin : g_tree
    // Heap-ordered tree: node i sums nodes 2i+1 and 2i+2; leaves sit at NW-1 upward.
    logic [CW-1:0] node_q [NW-1];
    logic [CW-1:0] tree   [2*NW-1];

    always_comb begin
      for (int i = 0; i < NW - 1; i++) tree[i] = node_q[i];
      for (int w = 0; w < NW; w++) tree[NW-1+w] = leaf[w];
    end

    always_ff @(posedge clk_i) begin
      for (int i = 0; i < NW - 1; i++) begin
        node_q[i] <= tree[2*i+1] + tree[2*i+2];
      end
    end

    assign done_cnt = node_q[0];
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      vld_q <= '0;
      for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
    end else begin
      vld_q[0] <= issue_valid;
      tag_q[0] <= issue_tag;
      for (int i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign done_valid = vld_q[LAT-1];
  assign done_tag   = tag_q[LAT-1];

endmodule

// File: rtl/bpc_scheduler.sv
// Round-robin scheduler feeding a shared popcount pipeline; tracks per-requester
// in-flight counts and routes each result back to the requester that issued it.
module bpc_scheduler
  import bpc_pkg::*;
#(
  parameter int WIDTH     = 24,
  parameter int N_REQ     = 4,
  parameter int MAX_OUTST = 2
) (
  input  logic                              clk_i,
  input  logic                              arst_ni,
  input  logic [N_REQ-1:0][WIDTH-1:0]       req_data_i,
  input  logic [N_REQ-1:0]                  req_valid_i,
  output logic [N_REQ-1:0]                  req_ready_o,
  input  logic [N_REQ-1:0]                  req_en_i,
  output logic [N_REQ-1:0]                  rsp_valid_o,
  output logic [cnt_w(WIDTH)-1:0]           rsp_cnt_o,
  output logic                              busy_o
);

  localparam int CW = cnt_w(WIDTH);
  localparam int TW = tag_w(N_REQ);
  localparam int OW = $clog2(MAX_OUTST + 1);

  logic [TW-1:0]    rr_ptr;
  logic [OW-1:0]    outst [N_REQ];
  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] done;
  logic             gnt_any;
  logic [TW-1:0]    gnt_idx;
  logic             hi_any;
  logic             lo_any;
  logic [TW-1:0]    hi_idx;
  logic [TW-1:0]    lo_idx;
  logic             done_valid;
  logic [TW-1:0]    done_tag;
  logic [CW-1:0]    done_cnt;

  assign done = done_valid ? (N_REQ'(1) << done_tag) : '0;

  // A slot freed by a response in this same cycle may be reused immediately.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      elig[i] = arst_ni & req_valid_i[i] & req_en_i[i] &
                ((outst[i] < OW'(MAX_OUTST)) | done[i]);
    end
  end

  // Lowest eligible index above the pointer wins; otherwise wrap to the lowest overall.
  always_comb begin
    hi_any = 1'b0;
    lo_any = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (elig[i]) begin
        if (TW'(i) > rr_ptr) begin
          hi_any = 1'b1;
          hi_idx = TW'(i);
        end else begin
          lo_any = 1'b1;
          lo_idx = TW'(i);
        end
      end
    end
    gnt_any = hi_any | lo_any;
    gnt_idx = hi_any ? hi_idx : lo_idx;
    grant   = gnt_any ? (N_REQ'(1) << gnt_idx) : '0;
  end

  assign req_ready_o = grant;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      rr_ptr <= TW'(N_REQ - 1);
      for (int i = 0; i < N_REQ; i++) outst[i] <= '0;
    end else begin
      if (gnt_any) rr_ptr <= gnt_idx;
      for (int i = 0; i < N_REQ; i++) begin
        if (grant[i] && !done[i]) begin
          outst[i] <= outst[i] + OW'(1);
        end else if (!grant[i] && done[i]) begin
          outst[i] <= outst[i] - OW'(1);
        end
      end
    end
  end

  always_comb begin
    busy_o = 1'b0;
    for (int i = 0; i < N_REQ; i++) busy_o = busy_o | (outst[i] != '0);
  end

  popcount_pipe #(
    .WIDTH (WIDTH),
    .TAG_W (TW)
  ) u_pipe (
    .clk_i       (clk_i),
    .arst_ni     (arst_ni),
    .issue_valid (gnt_any),
    .issue_tag   (gnt_idx),
    .issue_data  (req_data_i[gnt_idx]),
    .done_valid  (done_valid),
    .done_tag    (done_tag),
    .done_cnt    (done_cnt)
  );

  assign rsp_valid_o = done;
  assign rsp_cnt_o   = done_valid ? done_cnt : '0;

endmodule
